// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and widths for the instruction prefetch buffer.
// Optional perf counters are enabled in the top by defining IFB_PERF_EN.
package inst_fetch_buf_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned IFB_DEPTH = 4;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } ifb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ifb_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_buf_fifo.sv
// Synchronous FIFO of {pc, inst} entries with push, pop and clear.
// Head is read straight from the storage registers, so it appears one cycle after push.
module inst_fetch_buf_fifo
    import inst_fetch_buf_pkg::*;
#(
    parameter  int unsigned DEPTH = IFB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  ifb_entry_t       wdata,
    output ifb_entry_t       rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    ifb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push into a full FIFO is legal then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction prefetch: owns the PC, issues in-order reads under a credit limit, queues returns.
// Define IFB_PERF_EN to add saturating pop and starved-consumer counters.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int unsigned       DEPTH    = IFB_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i
`ifdef IFB_PERF_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_bubble_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    ifb_state_e        state_q;
    ifb_state_e        state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] rsp_pc_q;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_d;
    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              credit_ok;
    logic              issue;
    logic              rsp_live;
    logic              rsp_accept;
    logic              pop;
    ifb_entry_t        q_wdata;
    ifb_entry_t        q_head;

    assign redirect_pc = word_align(flush_pc_i);
    // Queued plus in-flight words never exceed DEPTH, so every response has a slot.
    assign credit_ok   = (SUM_W'(q_count) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
    assign pop         = id_valid_o && id_ready_i;

    // Next-state, request and counter updates.
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        mem_req_o     = 1'b0;
        issue         = 1'b0;
        rsp_accept    = 1'b0;
        rsp_live      = mem_rvalid_i && (outstanding_q != '0);

        case (state_q)
            S_RUN: begin
                mem_req_o = !rst && !flush_i && credit_ok;
                issue     = mem_req_o && mem_gnt_i;
                if (flush_i) begin
                    // A response arriving with the flush is dropped on the spot.
                    outstanding_d = '0;
                    drop_cnt_d    = outstanding_q - CNT_W'(rsp_live);
                    if (drop_cnt_d != '0) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    rsp_accept    = rsp_live;
                    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_live);
                end
            end
            S_DRAIN: begin
                if (mem_rvalid_i && (drop_cnt_q != '0)) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end
                if (drop_cnt_d == '0) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            if (flush_i) begin
                fetch_pc_q <= redirect_pc;
                rsp_pc_q   <= redirect_pc;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                end
                if (rsp_accept) begin
                    rsp_pc_q <= rsp_pc_q + ADDR_W'(4);
                end
            end
        end
    end

    assign mem_addr_o   = fetch_pc_q;
    assign q_wdata.pc   = rsp_pc_q;
    assign q_wdata.inst = mem_rdata_i;

    inst_fetch_buf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_accept),
        .pop   (pop),
        .clear (flush_i),
        .wdata (q_wdata),
        .rdata (q_head),
        .count (q_count),
        .empty (q_empty)
    );

    assign id_valid_o = !q_empty;
    assign id_pc_o    = q_head.pc;
    assign id_inst_o  = q_head.inst;

`ifdef IFB_PERF_EN
    // Saturating counters: pops taken, and cycles the consumer waited on an empty queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_o  <= '0;
            perf_bubble_o <= '0;
        end else begin
            if (pop && (perf_fetch_o != '1)) begin
                perf_fetch_o <= perf_fetch_o + 32'd1;
            end
            if (id_ready_i && !id_valid_o && (perf_bubble_o != '1)) begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
        end
    end
`endif

    ap_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
        !((state_q == S_RUN) && !flush_i && mem_rvalid_i && (outstanding_q == '0)));

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Scoreboard bench for inst_fetch_buf: behavioural memory with programmable latency and grant.
// Perf counter checks are compiled in when IFB_PERF_EN is defined.
module tb_inst_fetch_buf;
    import inst_fetch_buf_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;
`ifdef IFB_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_bubble_o;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_chk;
    int          n_pass;
    int          lat;
    int          cyc;
    logic        gnt_en;
    logic        force_rv;
    pend_t       pend_q[$];
    ifb_entry_t  exp_q[$];
    logic [31:0] issue_log[$];

    inst_fetch_buf #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_ready_i   (id_ready_i)
`ifdef IFB_PERF_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_bubble_o (perf_bubble_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return {addr[15:0] ^ 16'h5A5A, ~addr[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Memory model: in-order responses 'lat' cycles after grant; expectations pushed at issue.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        cyc          = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (rst) begin
                pend_q.delete();
                mem_gnt_i = 1'b0;
            end else begin
                if (force_rv) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = 32'hDEAD_BEEF;
                end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    pend_t r;
                    r = pend_q.pop_front();
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = inst_of(r.addr);
                end
                mem_gnt_i = gnt_en;
                if (mem_req_o && mem_gnt_i) begin
                    ifb_entry_t e;
                    pend_q.push_back('{addr: mem_addr_o, due: cyc + lat});
                    issue_log.push_back(mem_addr_o);
                    e.pc   = mem_addr_o;
                    e.inst = inst_of(mem_addr_o);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Consumer monitor: every pop is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_q.delete();
            end else begin
                if (id_valid_o && id_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_has_expect", 32'(exp_q.size()), 32'd1);
                    end else begin
                        ifb_entry_t e;
                        e = exp_q.pop_front();
                        chk("pop_pc", id_pc_o, e.pc);
                        chk("pop_inst", id_inst_o, e.inst);
                    end
                end
                if (flush_i) exp_q.delete();
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_chk);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        flush_i  = 1'b0;
        force_rv = 1'b0;
        @(negedge clk);
        issue_log.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        #2;
        while (!id_valid_o && n < 30) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!id_valid_o) chk(tag, 32'(id_valid_o), 32'd1);
    endtask

    initial begin
        int          bubbles;
        logic        seen;
        logic [31:0] a;

        n_chk      = 0;
        n_pass     = 0;
        rst        = 1'b1;
        flush_i    = 1'b0;
        flush_pc_i = '0;
        id_ready_i = 1'b0;
        gnt_en     = 1'b0;
        lat        = 1;
        force_rv   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #2;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);

        // Streaming with 1-cycle memory and an always-ready consumer
        id_ready_i = 1'b1;
        gnt_en     = 1'b1;
        lat        = 1;
        do_reset();
        seen    = 1'b0;
        bubbles = 0;
        repeat (30) begin
            @(negedge clk);
            #2;
            if (id_valid_o) seen = 1'b1;
            else if (seen) bubbles++;
        end
        chk("stream_fill", 32'(seen), 32'd1);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        for (int i = 0; i < 5; i++) begin
            a = (issue_log.size() > i) ? issue_log[i] : 32'hFFFF_FFFF;
            chk("stream_addr", a, 32'(4 * i));
        end

        // Backpressure: credit limit, then one pop frees one credit
        id_ready_i = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        #2;
        chk("bp_issues", 32'(issue_log.size()), 32'd4);
        chk("bp_req", 32'(mem_req_o), 32'd0);
        chk("bp_addr", mem_addr_o, 32'h10);
        @(negedge clk);
        id_ready_i = 1'b1;
        #2;
        chk("bp_pop_no_credit", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        id_ready_i = 1'b0;
        #2;
        chk("bp_credit_req", 32'(mem_req_o), 32'd1);
        chk("bp_credit_addr", mem_addr_o, 32'h10);
        @(negedge clk);
        #2;
        chk("bp_issues2", 32'(issue_log.size()), 32'd5);
        id_ready_i = 1'b1;
        repeat (12) @(negedge clk);

        // Grant withheld: request and address held
        gnt_en = 1'b0;
        do_reset();
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("nognt_req", 32'(mem_req_o), 32'd1);
            chk("nognt_addr", mem_addr_o, 32'h0);
        end
        @(negedge clk);
        gnt_en = 1'b1;
        #2;
        chk("gnt_issue", 32'(issue_log.size()), 32'd1);
        @(negedge clk);
        #2;
        chk("gnt_advance", mem_addr_o, 32'h4);
        repeat (10) @(negedge clk);

        // Flush with three reads in flight at latency 3
        lat        = 3;
        gnt_en     = 1'b1;
        id_ready_i = 1'b1;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        gnt_en     = 1'b0;
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_0103;
        #2;
        chk("fl3_issued", 32'(issue_log.size()), 32'd3);
        chk("fl3_req_flush", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        gnt_en  = 1'b1;
        #2;
        chk("fl3_drain_req0", 32'(mem_req_o), 32'd0);
        chk("fl3_drain_valid", 32'(id_valid_o), 32'd0);
        @(negedge clk);
        #2;
        chk("fl3_drain_req1", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        #2;
        chk("fl3_redir_req", 32'(mem_req_o), 32'd1);
        chk("fl3_redir_addr", mem_addr_o, 32'h100);
        wait_valid("fl3_wait_valid");
        chk("fl3_first_pc", id_pc_o, 32'h100);
        repeat (10) @(negedge clk);

        // Flush with nothing in flight and a stray same-cycle response
        lat    = 1;
        gnt_en = 1'b0;
        do_reset();
        repeat (2) @(negedge clk);
        @(negedge clk);
        flush_i    = 1'b1;
        flush_pc_i = 32'h200;
        force_rv   = 1'b1;
        #2;
        chk("fl0_req_flush", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        flush_i  = 1'b0;
        force_rv = 1'b0;
        gnt_en   = 1'b1;
        #2;
        chk("fl0_req", 32'(mem_req_o), 32'd1);
        chk("fl0_addr", mem_addr_o, 32'h200);
        chk("fl0_valid", 32'(id_valid_o), 32'd0);
        wait_valid("fl0_wait_valid");
        chk("fl0_first_pc", id_pc_o, 32'h200);
        repeat (10) @(negedge clk);

`ifdef IFB_PERF_EN
        // Perf counters: 3 starved cycles, then exactly 10 pops
        id_ready_i = 1'b0;
        gnt_en     = 1'b0;
        lat        = 1;
        do_reset();
        repeat (3) begin
            @(negedge clk);
            id_ready_i = 1'b1;
        end
        @(negedge clk);
        id_ready_i = 1'b0;
        gnt_en     = 1'b1;
        repeat (8) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            id_ready_i = 1'b1;
        end
        @(negedge clk);
        id_ready_i = 1'b0;
        #2;
        chk("perf_fetch", perf_fetch_o, 32'd10);
        chk("perf_bubble", perf_bubble_o, 32'd3);
`endif

        // Asynchronous reset in the middle of traffic
        lat        = 3;
        gnt_en     = 1'b1;
        id_ready_i = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("mid_rst_req", 32'(mem_req_o), 32'd0);
        chk("mid_rst_addr", mem_addr_o, 32'h0);
        chk("mid_rst_valid", 32'(id_valid_o), 32'd0);
        chk("mid_rst_pc", id_pc_o, 32'h0);
        chk("mid_rst_inst", id_inst_o, 32'h0);
`ifdef IFB_PERF_EN
        chk("mid_rst_perf_fetch", perf_fetch_o, 32'd0);
        chk("mid_rst_perf_bubble", perf_bubble_o, 32'd0);
`endif
        @(negedge clk);
        issue_log.delete();
        rst        = 1'b0;
        id_ready_i = 1'b1;
        wait_valid("mid_rst_wait_valid");
        chk("mid_rst_restart_pc", id_pc_o, 32'h0);
        repeat (20) @(negedge clk);
        #2;
        a = (issue_log.size() > 0) ? issue_log[0] : 32'hFFFF_FFFF;
        chk("mid_rst_first_addr", a, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
